// File: rtl/mmio_responder.sv
// Memory-mapped responder: cycle counter, countdown timer with interrupt,
// and an output FIFO drained through a valid/ready handshake.
module mmio_responder #(
   parameter logic [31:0] BASE  = 32'hFFFF_FF00,
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemEn,
   input  logic        MemWen,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        sel,
   output logic        irq,
   output logic        print_valid,
   output logic [31:0] print_data,
   input  logic        print_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   localparam logic [7:0] OFF_CYCLE  = 8'h00;
   localparam logic [7:0] OFF_LOAD   = 8'h04;
   localparam logic [7:0] OFF_CTRL   = 8'h08;
   localparam logic [7:0] OFF_VAL    = 8'h0C;
   localparam logic [7:0] OFF_STATUS = 8'h10;
   localparam logic [7:0] OFF_FIFO   = 8'h14;

   logic [31:0] cycle_q, cycle_d;
   logic [31:0] load_q, load_d;
   logic        en_q, en_d;
   logic        auto_q, auto_d;
   logic        irq_en_q, irq_en_d;
   logic [31:0] val_q, val_d;
   logic        expired_q, expired_d;
   logic        overflow_q, overflow_d;
   logic [31:0] mem_q [DEPTH];
   logic [31:0] mem_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [31:0] data_out_q, data_out_d;

   logic [7:0]  off;
   logic        aligned;
   logic        wr_ok;
   logic        rd_req;
   logic        full;
   logic        empty;
   logic        push_req;
   logic        push;
   logic        pop;
   logic [31:0] rdata;

   assign sel         = (addr_in[31:8] == BASE[31:8]);
   assign off         = addr_in[7:0];
   assign aligned     = (addr_in[1:0] == 2'b00);
   assign wr_ok       = MemEn & sel & MemWen & aligned;
   assign rd_req      = MemEn & sel & ~MemWen;
   assign full        = (cnt_q == FULL_CNT);
   assign empty       = (cnt_q == '0);
   assign push_req    = wr_ok & (off == OFF_FIFO);
   assign push        = push_req & ~full;
   assign pop         = ~empty & print_ready;

   assign data_out    = data_out_q;
   assign irq         = expired_q & irq_en_q;
   assign print_valid = ~empty;
   assign print_data  = empty ? '0 : mem_q[rptr_q];

   // Read mux over pre-edge state
   always_comb begin
      rdata = '0;
      case (off)
         OFF_CYCLE:  rdata = cycle_q;
         OFF_LOAD:   rdata = load_q;
         OFF_CTRL:   rdata = {29'd0, irq_en_q, auto_q, en_q};
         OFF_VAL:    rdata = val_q;
         OFF_STATUS: rdata = {24'd0, 4'(cnt_q), overflow_q, empty, full, expired_q};
         default:    rdata = '0;
      endcase
   end

   // Next-state: register writes, timer, FIFO and read capture
   always_comb begin
      cycle_d    = cycle_q + 32'd1;
      load_d     = load_q;
      en_d       = en_q;
      auto_d     = auto_q;
      irq_en_d   = irq_en_q;
      val_d      = val_q;
      expired_d  = expired_q;
      overflow_d = overflow_q;
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;

      // W1C clears are applied first so a same-cycle set below wins
      if (wr_ok) begin
         case (off)
            OFF_LOAD: load_d = data_in;
            OFF_CTRL: begin
               en_d     = data_in[0];
               auto_d   = data_in[1];
               irq_en_d = data_in[2];
            end
            OFF_STATUS: begin
               if (data_in[0]) expired_d  = 1'b0;
               if (data_in[3]) overflow_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (wr_ok && off == OFF_CTRL) begin
         if (data_in[0]) val_d = load_q;
      end else if (en_q) begin
         if (val_q > 32'd1) begin
            val_d = val_q - 32'd1;
         end else if (val_q == 32'd1) begin
            expired_d = 1'b1;
            val_d     = auto_q ? load_q : '0;
         end
      end

      // Fullness is judged before any pop, so a same-cycle pop cannot rescue a write
      if (push_req && full) overflow_d = 1'b1;
      if (push) begin
         mem_d[wptr_q] = data_in;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;

      if (rd_req) data_out_d = aligned ? rdata : '0;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q    <= '0;
         load_q     <= '0;
         en_q       <= 1'b0;
         auto_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         val_q      <= '0;
         expired_q  <= 1'b0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         data_out_q <= '0;
      end else begin
         cycle_q    <= cycle_d;
         load_q     <= load_d;
         en_q       <= en_d;
         auto_q     <= auto_d;
         irq_en_q   <= irq_en_d;
         val_q      <= val_d;
         expired_q  <= expired_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
      end
   end

endmodule
